// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL/reset controller side and the sequencer.
// Inputs to the sequencer: pll_lock, rst_req. Outputs: sys_rst, sys_ready, state, lock_lost_cnt, pll_reset.
interface pll_reset_sequencer_if;
  logic       pll_lock;
  logic       rst_req;
  logic       sys_rst;
  logic       sys_ready;
  logic [1:0] state;
  logic [7:0] lock_lost_cnt;
  logic       pll_reset;

  modport master (
    output pll_lock,
    output rst_req,
    input  sys_rst,
    input  sys_ready,
    input  state,
    input  lock_lost_cnt,
    input  pll_reset
  );

  modport slave (
    input  pll_lock,
    input  rst_req,
    output sys_rst,
    output sys_ready,
    output state,
    output lock_lost_cnt,
    output pll_reset
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL lock qualifier and system reset sequencer for the 84 MHz PLL domain.
// Ports: clkin, reset (sync, active-high), bus (slave: pll_lock, rst_req in;
//   sys_rst, sys_ready, state, lock_lost_cnt, pll_reset out).
// Optional macro PLL_RST_TIMEOUT_EN adds a WAIT_LOCK watchdog driving pll_reset.
module pll_reset_sequencer #(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned RST_HOLD_CYCLES     = 84,
  parameter int unsigned CNT_W               = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65535
) (
  input  logic                 clkin,
  input  logic                 reset,
  pll_reset_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam longint unsigned CNT_MAX =
    (64'd1 << CNT_W) - 64'd1;

  if (SYNC_STAGES < 2 ||
      LOCK_STABLE_CYCLES < 1 ||
      RST_HOLD_CYCLES < 1 ||
      LOCK_TIMEOUT_CYCLES < 1 ||
      64'(LOCK_STABLE_CYCLES) > CNT_MAX ||
      64'(RST_HOLD_CYCLES) > CNT_MAX ||
      64'(LOCK_TIMEOUT_CYCLES) > CNT_MAX)
  begin : g_bad_cfg
    $error("pll_reset_sequencer: bad parameter set");
  end

  localparam logic [CNT_W-1:0] STABLE_LAST =
    CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(RST_HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             lost_q, lost_d;
  logic                   sys_rst_q;
  logic                   sys_ready_q;

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clkin) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_lock};
    end
  end

`ifdef PLL_RST_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
`ifdef PLL_RST_TIMEOUT_EN
          // Watchdog period restarts after each timeout
          if (cnt_q == TO_LAST) cnt_d = '0;
          else                  cnt_d = cnt_q + 1'b1;
`else
          cnt_d = '0;
`endif
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        cnt_d = '0;
        // Lock loss wins over a concurrent soft reset
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
        end else if (bus.rst_req) begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs follow the next state so they flip on the RUN entry/exit edge
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      lost_q      <= '0;
      sys_rst_q   <= 1'b1;
      sys_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lost_q      <= lost_d;
      sys_rst_q   <= (state_d != RUN);
      sys_ready_q <= (state_d == RUN);
    end
  end

`ifdef PLL_RST_TIMEOUT_EN
  logic       pll_rst_q, pll_rst_d;
  logic [3:0] pulse_q, pulse_d;

  always_comb begin
    pll_rst_d = pll_rst_q;
    pulse_d   = pulse_q;
    if (pll_rst_q) begin
      if (pulse_q == 4'hF) pll_rst_d = 1'b0;
      else                 pulse_d   = pulse_q + 4'd1;
    end
    if (state_q == WAIT_LOCK && !lock_s &&
        cnt_q == TO_LAST) begin
      pll_rst_d = 1'b1;
      pulse_d   = '0;
    end
    // Lock found mid-pulse: drop the PLL reset at once
    if (state_d != WAIT_LOCK) pll_rst_d = 1'b0;
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      pll_rst_q <= 1'b0;
      pulse_q   <= '0;
    end else begin
      pll_rst_q <= pll_rst_d;
      pulse_q   <= pulse_d;
    end
  end

  assign bus.pll_reset = pll_rst_q;
`else
  assign bus.pll_reset = 1'b0;
`endif

  assign bus.sys_rst       = sys_rst_q;
  assign bus.sys_ready     = sys_ready_q;
  assign bus.state         = state_q;
  assign bus.lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer (SYNC 2, STABLE 8, HOLD 4, TIMEOUT 32).
// Stimulus queues cycle-stamped expectations; a negedge monitor pops and compares.
module tb_pll_reset_sequencer;

  localparam int unsigned LSC = 8;
  localparam int unsigned RHC = 4;
  localparam int unsigned TOC = 32;
`ifdef PLL_RST_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic clkin = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .SYNC_STAGES        (2),
    .LOCK_STABLE_CYCLES (LSC),
    .RST_HOLD_CYCLES    (RHC),
    .CNT_W              (16),
    .LOCK_TIMEOUT_CYCLES(TOC)
  ) dut (
    .clkin(clkin),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clkin = ~clkin;
  always @(posedge clkin) cyc <= cyc + 1;

  typedef struct {
    int         at;
    string      nm;
    logic [1:0] st;
    logic       rst;
    logic       rdy;
    logic [7:0] lost;
    logic       pr;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  function automatic logic [7:0] sat(input int v);
    return (v > 255) ? 8'hFF : 8'(v);
  endfunction

  task automatic push_exp(input int dt, input string nm,
                          input logic [1:0] st,
                          input logic [7:0] lost,
                          input logic pr);
    exp_t e;
    e.at   = cyc + dt;
    e.nm   = nm;
    e.st   = st;
    e.rst  = (st != 2'd3);
    e.rdy  = (st == 2'd3);
    e.lost = lost;
    e.pr   = pr;
    sbq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clkin);
  endtask

  always @(negedge clkin) begin
    while (sbq.size() > 0 && sbq[0].at <= cyc) begin
      mon_e = sbq.pop_front();
      n_vec++;
      if (mon_e.at != cyc ||
          bus.state !== mon_e.st ||
          bus.sys_rst !== mon_e.rst ||
          bus.sys_ready !== mon_e.rdy ||
          bus.lock_lost_cnt !== mon_e.lost ||
          bus.pll_reset !== mon_e.pr) begin
        n_bad++;
        $display("FAIL %s cyc %0d (due %0d): got st=%0d rst=%b rdy=%b lost=%0d pr=%b, want st=%0d rst=%b rdy=%b lost=%0d pr=%b",
                 mon_e.nm, cyc, mon_e.at, bus.state, bus.sys_rst,
                 bus.sys_ready, bus.lock_lost_cnt, bus.pll_reset,
                 mon_e.st, mon_e.rst, mon_e.rdy, mon_e.lost, mon_e.pr);
      end
    end
  end

  initial begin
    bus.pll_lock = 1'b0;
    bus.rst_req  = 1'b0;
    reset        = 1'b1;
    @(negedge clkin);
    push_exp(1, "reset", 2'd0, 8'd0, 1'b0);
    step(2);

    // Plain lock-up: 15 edges to RUN
    reset = 1'b0;
    bus.pll_lock = 1'b1;
    push_exp(2,  "t1_wait",     2'd0, 8'd0, 1'b0);
    push_exp(3,  "t1_stable",   2'd1, 8'd0, 1'b0);
    push_exp(10, "t1_stab_end", 2'd1, 8'd0, 1'b0);
    push_exp(11, "t1_hold",     2'd2, 8'd0, 1'b0);
    push_exp(14, "t1_hold_end", 2'd2, 8'd0, 1'b0);
    push_exp(15, "t1_run",      2'd3, 8'd0, 1'b0);
    step(15);

    // Glitch during STABLE restarts qualification
    reset = 1'b1;
    bus.pll_lock = 1'b0;
    push_exp(1, "t2_reset", 2'd0, 8'd0, 1'b0);
    step(2);
    reset = 1'b0;
    bus.pll_lock = 1'b1;
    push_exp(3, "t2_stable", 2'd1, 8'd0, 1'b0);
    step(7);
    bus.pll_lock = 1'b0;
    push_exp(2, "t2_glitch_stab", 2'd1, 8'd0, 1'b0);
    push_exp(3, "t2_glitch_wait", 2'd0, 8'd0, 1'b0);
    step(3);
    bus.pll_lock = 1'b1;
    push_exp(2,  "t2_re_wait",   2'd0, 8'd0, 1'b0);
    push_exp(3,  "t2_re_stable", 2'd1, 8'd0, 1'b0);
    push_exp(14, "t2_re_hold",   2'd2, 8'd0, 1'b0);
    push_exp(15, "t2_re_run",    2'd3, 8'd0, 1'b0);
    step(15);

    // Repeated lock loss from RUN; counter saturates
    for (int i = 1; i <= 300; i++) begin
      bit chk;
      chk = (i <= 2) || (i == 255) || (i == 256) || (i == 300);
      bus.pll_lock = 1'b0;
      if (chk) begin
        push_exp(2, "t3_pre_loss", 2'd3, sat(i - 1), 1'b0);
        push_exp(3, "t3_loss",     2'd0, sat(i),     1'b0);
      end
      step(3);
      bus.pll_lock = 1'b1;
      if (chk) push_exp(15, "t3_rerun", 2'd3, sat(i), 1'b0);
      step(15);
    end

    // Soft reset from RUN; ignored in HOLD; loses to lock drop
    reset = 1'b1;
    push_exp(1, "t4_reset", 2'd0, 8'd0, 1'b0);
    step(2);
    reset = 1'b0;
    push_exp(15, "t4_run", 2'd3, 8'd0, 1'b0);
    step(15);
    bus.rst_req = 1'b1;
    push_exp(1, "t4_req_hold", 2'd2, 8'd0, 1'b0);
    step(1);
    bus.rst_req = 1'b0;
    step(1);
    bus.rst_req = 1'b1;
    push_exp(2, "t4_hold_last", 2'd2, 8'd0, 1'b0);
    push_exp(3, "t4_run_again", 2'd3, 8'd0, 1'b0);
    step(1);
    bus.rst_req = 1'b0;
    step(2);
    bus.pll_lock = 1'b0;
    push_exp(2, "t4_pre_race", 2'd3, 8'd0, 1'b0);
    step(2);
    bus.rst_req = 1'b1;
    push_exp(1, "t4_loss_vs_req", 2'd0, 8'd1, 1'b0);
    step(1);
    bus.rst_req = 1'b0;

    // Reset in the middle of HOLD
    bus.pll_lock = 1'b1;
    push_exp(11, "t5_hold", 2'd2, 8'd1, 1'b0);
    step(12);
    reset = 1'b1;
    push_exp(1, "t5_reset_hold", 2'd0, 8'd0, 1'b0);
    step(2);
    reset = 1'b0;
    push_exp(2,  "t5_wait",   2'd0, 8'd0, 1'b0);
    push_exp(3,  "t5_stable", 2'd1, 8'd0, 1'b0);
    push_exp(15, "t5_run",    2'd3, 8'd0, 1'b0);
    step(15);

    // WAIT_LOCK watchdog pulses, then lock mid-pulse
    reset = 1'b1;
    bus.pll_lock = 1'b0;
    step(2);
    reset = 1'b0;
    push_exp(31, "t6_pre_pulse", 2'd0, 8'd0, 1'b0);
    push_exp(32, "t6_pulse_on",  2'd0, 8'd0, TO_EN);
    push_exp(47, "t6_pulse_end", 2'd0, 8'd0, TO_EN);
    push_exp(48, "t6_pulse_off", 2'd0, 8'd0, 1'b0);
    push_exp(63, "t6_gap_end",   2'd0, 8'd0, 1'b0);
    push_exp(64, "t6_pulse2_on", 2'd0, 8'd0, TO_EN);
    step(68);
    bus.pll_lock = 1'b1;
    push_exp(2, "t6_mid_pulse", 2'd0, 8'd0, TO_EN);
    push_exp(3, "t6_lock_stab", 2'd1, 8'd0, 1'b0);
    step(3);

    step(3);
    if (sbq.size() != 0) begin
      $display("FAIL drain: %0d expectations never checked, want 0",
               sbq.size());
      n_vec += sbq.size();
      n_bad += sbq.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the 27-to-84 MHz rPLL and runs on the PLL output clock.
- Synchronises the PLL lock flag and waits until lock has been stable for a set time.
- Holds the system reset for a minimum number of cycles, then releases it.
- Re-enters reset on lock loss or a soft-reset request, and counts lock-loss events for debug.

Parameters:
- SYNC_STAGES, 2: flops in the pll_lock synchroniser (≥2).
- LOCK_STABLE_CYCLES, 1024: consecutive cycles of synchronised lock required before reset hold.
- RST_HOLD_CYCLES, 84: cycles sys_rst stays asserted after lock is qualified (1 µs at 84 MHz).
- CNT_W, 16: width of the shared phase counter; must hold max(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES).
- LOCK_TIMEOUT_CYCLES, 65535: WAIT_LOCK watchdog limit; used only with PLL_RST_TIMEOUT_EN.

Ports:
- clkin  in  1  84 MHz PLL output clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- pll_lock  in  1  PLL lock, asynchronous to clkin.
- rst_req  in  1  synchronous soft-reset request, single-cycle pulse.
- sys_rst  out  1  registered, active-high system reset for the 84 MHz domain.
- sys_ready  out  1  registered; high only in RUN.
- state  out  2  current FSM state: 0 WAIT_LOCK, 1 STABLE, 2 HOLD, 3 RUN.
- lock_lost_cnt  out  8  saturating count of RUN→WAIT_LOCK lock-loss events.
- pll_reset  out  1  reset request back to the PLL (see Optional Feature).

Behaviour:
- Reset (synchronous, highest priority):
  - state=WAIT_LOCK, sys_rst=1, sys_ready=0, lock_lost_cnt=0, counter=0, pll_reset=0.
  - Synchroniser flops cleared to 0.
- lock_s is the last synchroniser stage. A pll_lock rise is visible as lock_s=1 after SYNC_STAGES edges.
- WAIT_LOCK:
  - lock_s=1 → STABLE, counter=0.
- STABLE:
  - lock_s=0 → WAIT_LOCK.
  - Otherwise, counter==LOCK_STABLE_CYCLES-1 → HOLD with counter=0; else counter+1.
  - Occupies exactly LOCK_STABLE_CYCLES cycles.
- HOLD:
  - lock_s=0 → WAIT_LOCK.
  - Otherwise, counter==RST_HOLD_CYCLES-1 → RUN; else counter+1.
  - Occupies exactly RST_HOLD_CYCLES cycles.
- RUN:
  - lock_s=0 → WAIT_LOCK and lock_lost_cnt+1, saturating at 255.
  - Else rst_req=1 → HOLD with counter=0.
  - Lock loss has priority over rst_req in the same cycle; lock_lost_cnt still increments.
  - rst_req is ignored in all other states.
- Outputs:
  - sys_rst=0 and sys_ready=1 on the same edge the FSM enters RUN.
  - sys_rst=1 and sys_ready=0 on the same edge the FSM leaves RUN.
  - No combinational paths from inputs to outputs.
- Latency: from the first clkin edge sampling pll_lock=1, sys_rst falls after SYNC_STAGES+1+LOCK_STABLE_CYCLES+RST_HOLD_CYCLES edges, provided lock stays high.
- Glitches:
  - A lock drop reaching lock_s during STABLE or HOLD restarts qualification from WAIT_LOCK.
  - Drops shorter than one clkin period may be missed; this is acceptable.
- Counter never wraps: it is reset on every state entry and bounded by the compare.

Optional Feature:
- Macro: PLL_RST_TIMEOUT_EN.
- Defined:
  - The counter also runs in WAIT_LOCK.
  - When it reaches LOCK_TIMEOUT_CYCLES-1, pll_reset goes high for 16 cycles and the counter restarts at 0.
  - The FSM stays in WAIT_LOCK.
  - lock_s=1 during the pulse → STABLE immediately, with pll_reset forced to 0 on the same edge.
  - reset clears the pulse.
- Not defined:
  - pll_reset is tied to 0 and no timeout logic is built.
  - The port list is identical in both builds.

Test Plan (SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, RST_HOLD_CYCLES=4):
1. Reset, then pll_lock=1 held → sys_rst falls and sys_ready rises exactly 15 edges after the first sampling edge; state sequence 0,1,2,3.
2. Lock qualifies, then pll_lock drops for 3 cycles during STABLE (cycle 5) → returns to WAIT_LOCK; sys_rst held; full 15-edge sequence restarts after lock returns; lock_lost_cnt=0.
3. In RUN, drop pll_lock → sys_rst=1 two edges after the drop plus one, state=0, lock_lost_cnt=1. Repeat 300 times → saturates at 255.
4. In RUN, rst_req pulse → sys_rst high for exactly 4 cycles, then RUN. rst_req in the same cycle as lock_s fall → WAIT_LOCK and lock_lost_cnt increments.
5. Assert reset mid-HOLD → next edge state=0, sys_rst=1, counters 0; the sequence restarts after reset deasserts.
6. With PLL_RST_TIMEOUT_EN and LOCK_TIMEOUT_CYCLES=32, lock held low → pll_reset high for 16 cycles every 32. Raise lock mid-pulse → pll_reset=0 and state=1 on the next lock_s edge. Without the macro → pll_reset is always 0.
